// File: rtl/sample_bus_pkg.sv
// Shared definitions for the per-pin sample bus: command codes, frame layout,
// collector register map and the collector scan FSM encoding.
package sample_bus_pkg;

  localparam logic [15:0] CMD_START_OUTPUT = 16'd1;
  localparam logic [15:0] CMD_CONST_LOW    = 16'd2;
  localparam logic [15:0] CMD_INPUT_STREAM = 16'd3;
  localparam logic [15:0] CMD_CONST_HIGH   = 16'd4;
  localparam logic [15:0] CMD_RESET        = 16'd5;
  localparam logic [15:0] CMD_FLUSH        = 16'd6;

  // Marker occupies word[15:1]: 12'hABC followed by 3'b111; word[0] is the pin bit.
  localparam logic [14:0] FRAME_MARKER = {12'hABC, 3'b111};
  localparam int FRAME_LSB = 1;
  localparam int FRAME_MSB = 15;
  localparam int CNT_LSB   = 16;
  localparam int CNT_MSB   = 30;

  localparam logic [7:0] REG_CMD     = 8'd0;
  localparam logic [7:0] REG_MASK    = 8'd1;
  localparam logic [7:0] REG_PERIOD  = 8'd2;
  localparam logic [7:0] REG_DATA_LO = 8'd3;
  localparam logic [7:0] REG_DATA_HI = 8'd4;
  localparam logic [7:0] REG_DATA_CH = 8'd5;
  localparam logic [7:0] REG_COUNT   = 8'd6;
  localparam logic [7:0] REG_STATUS  = 8'd7;
  localparam logic [7:0] REG_DROPS   = 8'd8;

  typedef enum logic [5:0] {
    ST_IDLE    = 6'b000001,
    ST_WAIT    = 6'b000010,
    ST_REQ     = 6'b000100,
    ST_SETTLE  = 6'b001000,
    ST_CAPTURE = 6'b010000,
    ST_NEXT    = 6'b100000
  } collector_state_t;

  function automatic logic frame_valid(input logic [31:0] word);
    return word[FRAME_MSB:FRAME_LSB] == FRAME_MARKER;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO with flush; a push into a full FIFO succeeds only when a pop
// happens in the same cycle.
module sample_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  logic [WIDTH-1:0]        din,
  output logic [WIDTH-1:0]        head,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // DEPTH is a power of two, so the top count bit alone marks full.
  assign empty   = (count == '0);
  assign full    = count[AW];
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/sample_collector.sv
// Sample bus initiator: scans masked pin controllers, validates returned frames
// and queues {channel, word} for the host. SAMPLE_COLLECTOR_DEDUP_EN drops repeats.
module sample_collector #(
  parameter logic [7:0] POSITION     = 8'd240,
  parameter int         NUM_CHANNELS = 8,
  parameter logic [7:0] CHANNEL_BASE = 8'd0,
  parameter int         FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [18:0] addr,
  input  logic        data_wr,
  input  logic        data_rd,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        output_sample,
  output logic [7:0]  channel_select,
  input  logic [31:0] sample_data,
  output logic        fifo_nempty
);
  import sample_bus_pkg::*;

  collector_state_t state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [15:0] wait_q, wait_d;
  logic [15:0] mask_q, period_q, drops_q;
  logic        overflow_q;
  logic [7:0]  ch_sel_q;

  logic        blk_hit, wr_hit, rd_hit, addr_unused;
  logic        cmd_start, cmd_stop, cmd_flush;
  logic        cap_valid, cap_bad, dup, push_req, drop_full;
  logic        hit_found;
  logic [4:0]  hit_idx;
  logic [15:0] rd_val;

  logic                         fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [39:0]                  fifo_head;
  logic [$clog2(FIFO_DEPTH):0]  fifo_count;

  // Host access: a strobe with enable and a matching block is one access per cycle;
  // reads return data on the following cycle, writes take effect on the same edge.
  assign blk_hit     = enable && (addr[15:8] == POSITION);
  assign wr_hit      = blk_hit && data_wr;
  assign rd_hit      = blk_hit && data_rd;
  assign addr_unused = ^addr[18:16];
  assign cmd_start   = wr_hit && (addr[7:0] == REG_CMD) && (data_in == CMD_START_OUTPUT);
  assign cmd_stop    = wr_hit && (addr[7:0] == REG_CMD) && (data_in == CMD_RESET);
  assign cmd_flush   = wr_hit && (addr[7:0] == REG_CMD) && (data_in == CMD_FLUSH);

  // Lowest enabled scan index at or above the current one.
  always_comb begin
    hit_found = 1'b0;
    hit_idx   = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (mask_q[i] && (5'(i) >= idx_q)) begin
        hit_found = 1'b1;
        hit_idx   = 5'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wait_d    = wait_q;
    cap_valid = 1'b0;
    cap_bad   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_start) begin
          state_d = ST_WAIT;
          wait_d  = period_q;
        end
      end
      ST_WAIT: begin
        if (wait_q == '0) begin
          state_d = ST_NEXT;
          idx_d   = '0;
        end else begin
          wait_d = wait_q - 16'd1;
        end
      end
      ST_NEXT: begin
        if (hit_found) begin
          state_d = ST_REQ;
          idx_d   = hit_idx;
        end else begin
          state_d = ST_WAIT;
          wait_d  = period_q;
        end
      end
      ST_REQ:    state_d = ST_SETTLE;
      ST_SETTLE: state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        cap_valid = frame_valid(sample_data);
        cap_bad   = !frame_valid(sample_data);
        idx_d     = idx_q + 5'd1;
        state_d   = ST_NEXT;
      end
      default: state_d = ST_IDLE;
    endcase
    if (cmd_stop && (state_q != ST_IDLE)) begin
      state_d   = ST_IDLE;
      cap_valid = 1'b0;
      cap_bad   = 1'b0;
    end
  end

`ifdef SAMPLE_COLLECTOR_DEDUP_EN
  logic [14:0] last_cnt_q [16];

  assign dup = (last_cnt_q[idx_q[3:0]] == sample_data[CNT_MSB:CNT_LSB]);

  always_ff @(posedge clk) begin
    if (!reset || cmd_start) begin
      for (int i = 0; i < 16; i++) last_cnt_q[i] <= '0;
    end else if (cap_valid) begin
      last_cnt_q[idx_q[3:0]] <= sample_data[CNT_MSB:CNT_LSB];
    end
  end
`else
  assign dup = 1'b0;
`endif

  assign push_req  = cap_valid && !dup;
  assign fifo_pop  = rd_hit && (addr[7:0] == REG_DATA_HI) && !fifo_empty;
  assign fifo_push = push_req && (!fifo_full || fifo_pop);
  assign drop_full = push_req && fifo_full && !fifo_pop;

  sample_fifo #(
    .WIDTH (40),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (cmd_flush),
    .din   ({ch_sel_q, sample_data}),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      wait_q     <= '0;
      ch_sel_q   <= '0;
      mask_q     <= '0;
      period_q   <= '0;
      overflow_q <= 1'b0;
      drops_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      if (state_d == ST_REQ) ch_sel_q <= CHANNEL_BASE + 8'(idx_d);
      if (wr_hit && (addr[7:0] == REG_MASK))   mask_q   <= data_in;
      if (wr_hit && (addr[7:0] == REG_PERIOD)) period_q <= data_in;
      if (cmd_flush) begin
        overflow_q <= 1'b0;
        drops_q    <= '0;
      end else begin
        if (drop_full) overflow_q <= 1'b1;
        if ((drop_full || cap_bad) && (drops_q != 16'hFFFF)) drops_q <= drops_q + 16'd1;
      end
    end
  end

  always_comb begin
    rd_val = '0;
    case (addr[7:0])
      REG_MASK:    rd_val = mask_q;
      REG_PERIOD:  rd_val = period_q;
      REG_DATA_LO: rd_val = fifo_empty ? 16'h0 : fifo_head[15:0];
      REG_DATA_HI: rd_val = fifo_empty ? 16'h0 : fifo_head[31:16];
      REG_DATA_CH: rd_val = fifo_empty ? 16'h0 : {8'h0, fifo_head[39:32]};
      REG_COUNT:   rd_val = 16'(fifo_count);
      REG_STATUS:  rd_val = {13'b0, overflow_q, (state_q != ST_IDLE), !fifo_empty};
      REG_DROPS:   rd_val = drops_q;
      default:     rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset)      data_out <= '0;
    else if (rd_hit) data_out <= rd_val;
    else             data_out <= '0;
  end

  assign output_sample  = (state_q == ST_REQ);
  assign channel_select = ch_sel_q;
  assign fifo_nempty    = !fifo_empty;

endmodule

// File: tb/tb_sample_collector.sv
// Directed bench for sample_collector: register vector table plus hand-written
// scan, drop, overflow, stop and dedup sequences against a model queue.
module tb_sample_collector;
  localparam logic [7:0] POS      = 8'd240;
  localparam logic [7:0] R_CMD    = 8'd0;
  localparam logic [7:0] R_MASK   = 8'd1;
  localparam logic [7:0] R_PERIOD = 8'd2;
  localparam logic [7:0] R_LO     = 8'd3;
  localparam logic [7:0] R_HI     = 8'd4;
  localparam logic [7:0] R_CH     = 8'd5;
  localparam logic [7:0] R_COUNT  = 8'd6;
  localparam logic [7:0] R_STATUS = 8'd7;
  localparam logic [7:0] R_DROPS  = 8'd8;
  localparam int NV = 17;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        data_wr = 1'b0;
  logic        data_rd = 1'b0;
  logic [18:0] addr = '0;
  logic [15:0] data_in = '0;
  logic [15:0] data_out;
  logic        output_sample;
  logic [7:0]  channel_select;
  logic [31:0] sample_data;
  logic        fifo_nempty;
  logic [31:0] resp [8];

  int total = 0;
  int bad = 0;
  logic [39:0] exp_q[$];
  logic [7:0]  req_ch[$];
  int          req_cyc[$];
  int          cyc = 0;
  int          run = 0;
  int          max_run = 0;

  typedef struct {
    logic        wr;
    logic [7:0]  blk;
    logic [7:0]  rg;
    logic [15:0] val;
    string       name;
  } vec_t;
  vec_t vecs [NV];

  always #5 clk = ~clk;

  sample_collector dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .addr           (addr),
    .data_wr        (data_wr),
    .data_rd        (data_rd),
    .data_in        (data_in),
    .data_out       (data_out),
    .output_sample  (output_sample),
    .channel_select (channel_select),
    .sample_data    (sample_data),
    .fifo_nempty    (fifo_nempty)
  );

  assign sample_data = resp[channel_select[2:0]];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (output_sample) begin
      req_ch.push_back(channel_select);
      req_cyc.push_back(cyc);
      run = run + 1;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, total=%0d", total);
    $fatal(1, "timeout");
  end

  function automatic vec_t mk(input logic wr, input logic [7:0] blk, input logic [7:0] rg,
                              input logic [15:0] val, input string name);
    vec_t v;
    v.wr = wr; v.blk = blk; v.rg = rg; v.val = val; v.name = name;
    return v;
  endfunction

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [7:0] blk, input logic [7:0] rg, input logic [15:0] d);
    @(negedge clk);
    enable = 1'b1; data_wr = 1'b1; addr = {3'b000, blk, rg}; data_in = d;
    @(negedge clk);
    enable = 1'b0; data_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] blk, input logic [7:0] rg, output logic [15:0] q);
    @(negedge clk);
    enable = 1'b1; data_rd = 1'b1; addr = {3'b000, blk, rg};
    @(negedge clk);
    q = data_out;
    enable = 1'b0; data_rd = 1'b0;
  endtask

  task automatic bus_rw(input logic [7:0] rg, input logic [15:0] d, output logic [15:0] q);
    @(negedge clk);
    enable = 1'b1; data_rd = 1'b1; data_wr = 1'b1; addr = {3'b000, POS, rg}; data_in = d;
    @(negedge clk);
    q = data_out;
    enable = 1'b0; data_rd = 1'b0; data_wr = 1'b0;
  endtask

  task automatic rd_check(input logic [7:0] rg, input logic [15:0] exp, input string name);
    logic [15:0] q;
    bus_read(POS, rg, q);
    check(name, q, exp);
  endtask

  task automatic cmd(input logic [15:0] code);
    bus_write(POS, R_CMD, code);
  endtask

  task automatic clear_log();
    req_ch.delete();
    req_cyc.delete();
    max_run = 0;
  endtask

  // Waits for n logged requests, then lets the last capture retire before returning.
  task automatic wait_reqs(input int n, input int limit, input string name);
    int k = 0;
    while (req_ch.size() < n && k < limit) begin
      @(posedge clk);
      k++;
    end
    check(name, req_ch.size(), n);
    repeat (3) @(negedge clk);
  endtask

  task automatic pop_check(input string tag);
    logic [39:0] e;
    e = exp_q.pop_front();
    rd_check(R_CH, {8'h0, e[39:32]}, {tag, "_ch"});
    rd_check(R_LO, e[15:0], {tag, "_lo"});
    rd_check(R_HI, e[31:16], {tag, "_hi"});
  endtask

  initial begin
    logic [15:0] q;
    for (int i = 0; i < 8; i++) resp[i] = 32'h0;

    vecs[0]  = mk(1'b0, POS,   R_MASK,   16'h0000, "rst_mask");
    vecs[1]  = mk(1'b0, POS,   R_PERIOD, 16'h0000, "rst_period");
    vecs[2]  = mk(1'b0, POS,   R_COUNT,  16'h0000, "rst_count");
    vecs[3]  = mk(1'b0, POS,   R_STATUS, 16'h0000, "rst_status");
    vecs[4]  = mk(1'b0, POS,   R_DROPS,  16'h0000, "rst_drops");
    vecs[5]  = mk(1'b0, POS,   R_LO,     16'h0000, "rst_data_lo");
    vecs[6]  = mk(1'b0, POS,   R_HI,     16'h0000, "rst_data_hi_empty");
    vecs[7]  = mk(1'b1, POS,   R_MASK,   16'h00A5, "wr_mask");
    vecs[8]  = mk(1'b0, POS,   R_MASK,   16'h00A5, "rd_mask");
    vecs[9]  = mk(1'b1, 8'd17, R_MASK,   16'h00FF, "wr_other_blk");
    vecs[10] = mk(1'b0, POS,   R_MASK,   16'h00A5, "mask_kept");
    vecs[11] = mk(1'b0, 8'd17, R_MASK,   16'h0000, "rd_other_blk");
    vecs[12] = mk(1'b1, POS,   R_PERIOD, 16'h0007, "wr_period");
    vecs[13] = mk(1'b0, POS,   R_PERIOD, 16'h0007, "rd_period");
    vecs[14] = mk(1'b1, POS,   R_CMD,    16'h0009, "wr_bad_cmd");
    vecs[15] = mk(1'b0, POS,   R_STATUS, 16'h0000, "bad_cmd_idle");
    vecs[16] = mk(1'b0, POS,   8'd9,     16'h0000, "rd_unmapped");

    // clock/reset
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_data_out", data_out, 16'h0);
    check("rst_output_sample", output_sample, 1'b0);
    check("rst_channel_select", channel_select, 8'h0);
    check("rst_fifo_nempty", fifo_nempty, 1'b0);

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].wr) begin
        bus_write(vecs[i].blk, vecs[i].rg, vecs[i].val);
      end else begin
        bus_read(vecs[i].blk, vecs[i].rg, q);
        check(vecs[i].name, q, vecs[i].val);
      end
    end

    // basic scan of channels 0 and 2
    resp[0] = 32'h0003ABCF;
    resp[2] = 32'h0007ABCE;
    bus_write(POS, R_MASK, 16'h0005);
    bus_write(POS, R_PERIOD, 16'h0003);
    clear_log();
    cmd(16'd1);
    wait_reqs(2, 100, "scan_req_count");
    cmd(16'd5);
    check("scan_ch_first", req_ch[0], 8'd0);
    check("scan_ch_second", req_ch[1], 8'd2);
    check("scan_req_spacing", req_cyc[1] - req_cyc[0], 4);
    check("scan_req_width", max_run, 1);
    exp_q.push_back({8'd0, resp[0]});
    exp_q.push_back({8'd2, resp[2]});
    rd_check(R_COUNT, 16'd2, "scan_count");
    rd_check(R_STATUS, 16'h0001, "scan_status");
    rd_check(R_CH, 16'h0000, "head_ch0");
    rd_check(R_LO, 16'hABCF, "head_lo");
    rd_check(R_COUNT, 16'd2, "count_after_lo");
    rd_check(R_HI, 16'h0003, "head_hi");
    rd_check(R_COUNT, 16'd1, "count_after_hi");
    exp_q.pop_front();
    pop_check("second_entry");
    rd_check(R_COUNT, 16'd0, "count_drained");
    rd_check(R_STATUS, 16'h0000, "status_drained");

    // invalid frame on channel 1
    resp[1] = 32'h0;
    bus_write(POS, R_MASK, 16'h0007);
    bus_write(POS, R_PERIOD, 16'h0000);
    clear_log();
    cmd(16'd1);
    wait_reqs(3, 100, "drop_req_count");
    cmd(16'd5);
    rd_check(R_DROPS, 16'd1, "drop_invalid");
    rd_check(R_COUNT, 16'd2, "drop_count");
    cmd(16'd6);
    rd_check(R_COUNT, 16'd0, "flush1_count");
    rd_check(R_DROPS, 16'd0, "flush1_drops");

    // overflow: 9 scans of 2 channels, host idle
    exp_q.delete();
    bus_write(POS, R_MASK, 16'h0005);
    clear_log();
    cmd(16'd1);
    wait_reqs(18, 400, "ovf_req_count");
    cmd(16'd5);
    rd_check(R_COUNT, 16'd16, "ovf_count");
    rd_check(R_STATUS, 16'h0005, "ovf_status");
    rd_check(R_DROPS, 16'd2, "ovf_drops");
    exp_q.push_back({8'd0, resp[0]});
    pop_check("ovf_head");
    rd_check(R_COUNT, 16'd15, "ovf_count_after_pop");
    cmd(16'd6);
    rd_check(R_COUNT, 16'd0, "flush2_count");
    rd_check(R_STATUS, 16'h0000, "flush2_status");
    rd_check(R_DROPS, 16'd0, "flush2_drops");

    // STOP in the cycle after the request
    bus_write(POS, R_MASK, 16'h0001);
    clear_log();
    cmd(16'd1);
    begin
      int k = 0;
      @(negedge clk);
      while (!output_sample && k < 50) begin
        @(negedge clk);
        k++;
      end
      check("stop_req_seen", output_sample, 1'b1);
    end
    @(negedge clk);
    enable = 1'b1; data_wr = 1'b1; addr = {3'b000, POS, R_CMD}; data_in = 16'd5;
    @(negedge clk);
    enable = 1'b0; data_wr = 1'b0;
    check("stop_sample_low", output_sample, 1'b0);
    check("stop_no_push", fifo_nempty, 1'b0);
    rd_check(R_STATUS, 16'h0000, "stop_idle");
    rd_check(R_DROPS, 16'd0, "stop_drops");
    rd_check(R_HI, 16'h0000, "pop_empty_hi");
    rd_check(R_COUNT, 16'd0, "pop_empty_count");
    repeat (10) @(negedge clk);
    check("stop_no_more_reqs", req_ch.size(), 1);

    // write and read of the same register in one cycle
    bus_rw(R_MASK, 16'h0033, q);
    check("rw_old_value", q, 16'h0001);
    rd_check(R_MASK, 16'h0033, "rw_new_value");

    // constant sample count over three scans
    resp[0] = 32'h0005ABCF;
    bus_write(POS, R_MASK, 16'h0001);
    clear_log();
    cmd(16'd1);
    wait_reqs(3, 100, "dedup_req_count");
    cmd(16'd5);
`ifdef SAMPLE_COLLECTOR_DEDUP_EN
    rd_check(R_COUNT, 16'd1, "dedup_count");
`else
    rd_check(R_COUNT, 16'd3, "repeat_count");
`endif
    rd_check(R_DROPS, 16'd0, "dedup_drops");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
